// File: rtl/fcvt_result_stage.sv
// fcvt_result_stage: result stage for float-to-word conversion.
// Saturates the raw converter result using the original operand, derives the
// {NV,DZ,OF,UF,NX} flags, queues results in a fixed 2-entry FIFO toward writeback,
// and accumulates sticky exception flags.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_valid/ready  upstream handshake; in_fp operand, in_int raw result, in_rd tag
//   out_valid/ready writeback handshake; out_data/out_rd/out_flags describe FIFO head
//   fflags          sticky accrued flags; fflags_clr clears them
module fcvt_result_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_fp,
  input  logic [31:0] in_int,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_flags,
  output logic [4:0]  fflags,
  input  logic        fflags_clr
);

  localparam logic [4:0] FlagNv = 5'b10000;
  localparam logic [4:0] FlagNx = 5'b00001;

  // Operand classification and result saturation
  logic        sgn;
  logic [7:0]  expo;
  logic [22:0] frac;
  logic        is_nan, pos_ovf, neg_ovf, is_min;
  logic [7:0]  lost_sh;
  logic [22:0] lost_mask;
  logic        inexact;
  logic [31:0] res_data;
  logic [4:0]  res_flags;

  always_comb begin
    sgn     = in_fp[31];
    expo    = in_fp[30:23];
    frac    = in_fp[22:0];
    is_nan  = (expo == 8'd255) && (frac != 23'd0);
    pos_ovf = !sgn && (expo >= 8'd158);
    neg_ovf = sgn && ((expo > 8'd158) || ((expo == 8'd158) && (frac != 23'd0)));
    is_min  = (in_fp == 32'hCF00_0000);
    // Fraction bits below the binary point when 127 <= e < 150: the low 150-e bits.
    lost_sh   = 8'd150 - expo;
    lost_mask = ~(23'h7F_FFFF << lost_sh);
    if (expo < 8'd127) begin
      inexact = (in_fp[30:0] != 31'd0);
    end else if (expo < 8'd150) begin
      inexact = ((frac & lost_mask) != 23'd0);
    end else begin
      inexact = 1'b0;
    end

    res_data  = in_int;
    res_flags = inexact ? FlagNx : 5'b00000;
    if (is_nan || pos_ovf) begin
      res_data  = 32'h7FFF_FFFF;
      res_flags = FlagNv;
    end else if (neg_ovf) begin
      res_data  = 32'h8000_0000;
      res_flags = FlagNv;
    end else if (is_min) begin
      res_data  = 32'h8000_0000;
      res_flags = 5'b00000;
    end
  end

  // 2-entry FIFO
  logic [31:0] data_q  [2];
  logic [4:0]  rd_q    [2];
  logic [4:0]  flags_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;
  logic [4:0]  fflags_q, fflags_d;
  logic        push, pop;

  assign in_ready  = !rst && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    out_data  = out_valid ? data_q[rd_ptr_q]  : 32'd0;
    out_rd    = out_valid ? rd_q[rd_ptr_q]    : 5'd0;
    out_flags = out_valid ? flags_q[rd_ptr_q] : 5'd0;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
    // A clear coincident with a pop keeps the popped flags.
    fflags_d  = (fflags_clr ? 5'd0 : fflags_q) | (pop ? out_flags : 5'd0);
  end

  assign fflags = fflags_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q[0]  <= 32'd0;
      data_q[1]  <= 32'd0;
      rd_q[0]    <= 5'd0;
      rd_q[1]    <= 5'd0;
      flags_q[0] <= 5'd0;
      flags_q[1] <= 5'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      fflags_q   <= 5'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q]  <= res_data;
        rd_q[wr_ptr_q]    <= in_rd;
        flags_q[wr_ptr_q] <= res_flags;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q  <= count_d;
      fflags_q <= fflags_d;
    end
  end

endmodule

// File: tb/tb_fcvt_result_stage.sv
module tb_fcvt_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_fp;
  logic [31:0] in_int;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [4:0]  out_flags;
  logic [4:0]  fflags;
  logic        fflags_clr;

  fcvt_result_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fp     (in_fp),
    .in_int    (in_int),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_flags (out_flags),
    .fflags    (fflags),
    .fflags_clr(fflags_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [4:0]  flags;
  } ent_t;

  ent_t       sb[$];
  logic [4:0] ff_model = 5'd0;
  int         total = 0;
  int         bad = 0;
  bit         rnd_run;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t model(input logic [31:0] fp, input logic [31:0] iv,
                                 input logic [4:0] rd);
    ent_t        r;
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    s = fp[31];
    e = fp[30:23];
    f = fp[22:0];
    r.rd = rd;
    if (e == 8'd255 && f != 0) begin
      r.data = 32'h7FFF_FFFF; r.flags = 5'h10;
    end else if (!s && e >= 8'd158) begin
      r.data = 32'h7FFF_FFFF; r.flags = 5'h10;
    end else if (s && (e > 8'd158 || (e == 8'd158 && f != 0))) begin
      r.data = 32'h8000_0000; r.flags = 5'h10;
    end else if (fp == 32'hCF00_0000) begin
      r.data = 32'h8000_0000; r.flags = 5'h00;
    end else begin
      r.data  = iv;
      r.flags = 5'h00;
      if (e < 8'd127) begin
        if (fp[30:0] != 0) r.flags = 5'h01;
      end else if (e < 8'd150) begin
        for (int i = 0; i < 23; i++)
          if (i <= 149 - int'(e) && f[i]) r.flags = 5'h01;
      end
    end
    return r;
  endfunction

  // Scoreboard monitor: sampled on the falling edge, inputs change only just after rising.
  always @(negedge clk) begin
    ent_t       head;
    logic [4:0] pf;
    bit         can_acc;
    if (!rst) begin
      can_acc = (sb.size() < 2);
      check("in_ready", {63'd0, in_ready}, {63'd0, can_acc});
      check("out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
      if (sb.size() != 0) begin
        head = sb[0];
        check("out_data", {32'd0, out_data}, {32'd0, head.data});
        check("out_rd", {59'd0, out_rd}, {59'd0, head.rd});
        check("out_flags", {59'd0, out_flags}, {59'd0, head.flags});
      end else begin
        check("idle_zero", {22'd0, out_data, out_rd, out_flags}, 64'd0);
      end
      check("fflags", {59'd0, fflags}, {59'd0, ff_model});
      pf = 5'd0;
      if (out_ready && sb.size() != 0) begin
        head = sb.pop_front();
        pf = head.flags;
      end
      ff_model = (fflags_clr ? 5'd0 : ff_model) | pf;
      if (in_valid && can_acc) sb.push_back(model(in_fp, in_int, in_rd));
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] fp, input logic [31:0] iv, input logic [4:0] rd);
    int n;
    in_fp = fp; in_int = iv; in_rd = rd; in_valid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 200) begin
      total++; bad++;
      $display("FAIL send_timeout got=stalled exp=accept");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_chk(input logic [31:0] fp, input logic [31:0] iv, input logic [4:0] rd,
                          input logic [31:0] ed, input logic [4:0] ef, input string tag);
    send(fp, iv, rd);
    @(negedge clk);
    check({tag, "_data"}, {32'd0, out_data}, {32'd0, ed});
    check({tag, "_flags"}, {59'd0, out_flags}, {59'd0, ef});
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    e = 8'($urandom_range(115, 160));
    if ($urandom_range(0, 9) == 0) e = 8'd255;
    f = 23'($urandom);
    if ($urandom_range(0, 3) == 0) f = f & 23'h7F_0000;
    return {1'($urandom), e, f};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_fp = '0; in_int = '0; in_rd = '0;
    out_ready = 1'b1; fflags_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_outs", {22'd0, out_data, out_rd, out_flags}, 64'd0);
    check("rst_fflags", {59'd0, fflags}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // 1.5 -> 2, inexact
    send(32'h3FC0_0000, 32'd2, 5'd5);
    @(negedge clk);
    check("fp1p5_data", {32'd0, out_data}, 64'd2);
    check("fp1p5_rd", {59'd0, out_rd}, 64'd5);
    check("fp1p5_flags", {59'd0, out_flags}, 64'h01);
    @(negedge clk);
    check("fp1p5_fflags", {59'd0, fflags}, 64'h01);
    @(posedge clk);
    #1;

    // Clear coincident with popping an NV entry keeps NV
    out_ready = 1'b0;
    send(32'h7FC0_0000, 32'h1000_0000, 5'd1);
    fflags_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 fflags_clr = 1'b0;
    @(negedge clk);
    check("clr_pop_fflags", {59'd0, fflags}, 64'h10);
    @(posedge clk);
    #1;

    send_chk(32'h7FC0_0000, 32'h1000_0000, 5'd2, 32'h7FFF_FFFF, 5'h10, "nan");
    send_chk(32'h4F32_D05E, 32'h1000_0000, 5'd3, 32'h7FFF_FFFF, 5'h10, "big");
    send_chk(32'hCF00_0000, 32'h8000_0000, 5'd4, 32'h8000_0000, 5'h00, "min");
    send_chk(32'hCF00_0001, 32'h8000_0000, 5'd6, 32'h8000_0000, 5'h10, "negovf");
    send_chk(32'h4120_0000, 32'd10, 5'd7, 32'd10, 5'h00, "ten");

    // Back-pressure: three back-to-back inputs, the third is held
    out_ready = 1'b0;
    send(32'h3F80_0000, 32'd1, 5'd10);
    send(32'h4000_0000, 32'd2, 5'd11);
    fork
      send(32'h4040_0000, 32'd3, 5'd12);
      begin
        @(negedge clk);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        check("full_head", {32'd0, out_data}, 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("full_hold", {32'd0, out_data}, 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Random traffic with random back-pressure
    rnd_run = 1'b1;
    fork
      begin
        for (int k = 0; k < 40; k++) send(rand_fp(), $urandom, 5'(k));
        rnd_run = 1'b0;
      end
      begin
        while (rnd_run) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
    #1;

    // Asynchronous reset with a full FIFO
    out_ready = 1'b0;
    send(32'h3FC0_0000, 32'd2, 5'd20);
    send(32'h7FC0_0000, 32'd0, 5'd21);
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_fflags", {59'd0, fflags}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd0);
    sb.delete();
    ff_model = 5'd0;
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("arst_ready_after", {63'd0, in_ready}, 64'd1);
    check("arst_no_stale", {63'd0, out_valid}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    send_chk(32'h4120_0000, 32'd10, 5'd9, 32'd10, 5'h00, "post_arst");
    repeat (3) @(posedge clk);
    #1;
    check("drained", {32'd0, sb.size()}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
